// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop serialiser.
// Frames go out back-to-back with no idle gap while the FIFO holds data.
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT    = 87,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Tx_DV,
  input  logic [7:0]                 i_Tx_Byte,
  output logic                       o_Tx_Ready,
  output logic [FIFO_DEPTH_LOG2:0]   o_Fifo_Count,
  output logic                       o_Tx_Serial,
  output logic                       o_Tx_Active,
  output logic                       o_Tx_Done,
  output logic                       o_Overflow
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0]            CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   DepthCnt = (FIFO_DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e state_q, state_d;

  logic [7:0]                 mem_q [Depth];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic [CntW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [7:0]                 shift_q, shift_d;

  logic push;
  logic pop;
  logic bit_end;

  // Full status comes from the registered count, so a pop on the same edge never frees a slot.
  assign o_Tx_Ready = (count_q < DepthCnt);
  assign push       = i_Tx_DV & o_Tx_Ready;
  assign bit_end    = (bit_cnt_q == CntLast);

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (i_Tx_DV & ~o_Tx_Ready);
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Serialiser next-state; pop is only raised while count_q is non-zero.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Line outputs decode straight from state so reset forces them without a clock edge.
  always_comb begin
    o_Tx_Serial = 1'b1;
    unique case (state_q)
      StStart: o_Tx_Serial = 1'b0;
      StData:  o_Tx_Serial = shift_q[bit_idx_q];
      default: o_Tx_Serial = 1'b1;
    endcase
  end

  assign o_Tx_Active  = (state_q != StIdle);
  assign o_Tx_Done    = (state_q == StStop) && bit_end;
  assign o_Fifo_Count = count_q;
  assign o_Overflow   = overflow_q;

  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: default build plus a CLKS_PER_BIT=4, depth-2 build.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_buffered;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       ready, serial, active, done, ovf;
  logic [2:0] count;

  logic       s_dv = 1'b0;
  logic [7:0] s_byte = 8'h00;
  logic       s_ready, s_serial, s_active, s_done, s_ovf;
  logic [1:0] s_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT   (87),
    .FIFO_DEPTH_LOG2(2)
  ) u_dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Tx_DV     (dv),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Ready  (ready),
    .o_Fifo_Count(count),
    .o_Tx_Serial (serial),
    .o_Tx_Active (active),
    .o_Tx_Done   (done),
    .o_Overflow  (ovf)
  );

  uart_tx_buffered #(
    .CLKS_PER_BIT   (4),
    .FIFO_DEPTH_LOG2(1)
  ) u_small (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Tx_DV     (s_dv),
    .i_Tx_Byte   (s_byte),
    .o_Tx_Ready  (s_ready),
    .o_Fifo_Count(s_count),
    .o_Tx_Serial (s_serial),
    .o_Tx_Active (s_active),
    .o_Tx_Done   (s_done),
    .o_Overflow  (s_ovf)
  );

  // Returns at the first falling edge (possibly the current one) where the line is low.
  task automatic wait_start(input int which, input int budget, output int waited,
                            output bit timeout);
    logic s;
    waited  = 0;
    timeout = 1'b0;
    s = (which == 0) ? serial : s_serial;
    while (s !== 1'b0) begin
      if (waited >= budget) begin
        timeout = 1'b1;
        return;
      end
      @(negedge clk);
      waited++;
      s = (which == 0) ? serial : s_serial;
    end
  endtask

  // Serial decoder: samples frame cycles first..10*cpb-1, the current edge being cycle 'first'.
  task automatic decode_frame(input int which, input int cpb, input int first,
                              output logic [7:0] b, output int bad, output int done_cnt,
                              output int done_pos, output int inact);
    logic s, a, d;
    int   bi;
    b = 8'h00; bad = 0; done_cnt = 0; done_pos = -1; inact = 0;
    for (int i = first; i < 10 * cpb; i++) begin
      if (i > first) @(negedge clk);
      if (which == 0) begin s = serial; a = active; d = done; end
      else begin s = s_serial; a = s_active; d = s_done; end
      bi = i / cpb;
      if (bi == 0) begin
        if (s !== 1'b0) bad++;
      end else if (bi == 9) begin
        if (s !== 1'b1) bad++;
      end else if ((i % cpb == 0) || (i == first)) begin
        b[bi-1] = s;
      end else if (s !== b[bi-1]) begin
        bad++;
      end
      if (a !== 1'b1) inact++;
      if (d === 1'b1) begin done_cnt++; done_pos = i; end
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    checks++; if (serial !== 1'b1) begin errors++; $display("FAIL reset_serial: got %b want 1", serial); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (serial !== 1'b1 || active !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: got serial %b active %b want 1 0", serial, active);
    end
  endtask

  task automatic test_single;
    logic [7:0] b; int bad, dc, dp, ina, w; bit to;
    dv = 1'b1; tx_byte = 8'hAB;
    @(negedge clk);
    dv = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_queued: got %0d want 1", count); end
    checks++; if (serial !== 1'b1) begin errors++; $display("FAIL single_preline: got %b want 1", serial); end
    wait_start(0, 5, w, to);
    checks++; if (to || w != 1) begin errors++; $display("FAIL single_latency: got %0d cycles (timeout %b) want 1", w, to); end
    decode_frame(0, 87, 0, b, bad, dc, dp, ina);
    checks++; if (b !== 8'hAB) begin errors++; $display("FAIL single_byte: got %h want ab", b); end
    checks++; if (bad != 0) begin errors++; $display("FAIL single_shape: got %0d bad samples want 0", bad); end
    checks++; if (dc != 1 || dp != 869) begin errors++; $display("FAIL single_done: got %0d pulses at %0d want 1 at 869", dc, dp); end
    checks++; if (ina != 0) begin errors++; $display("FAIL single_active: got %0d inactive cycles want 0", ina); end
    @(negedge clk);
    checks++; if (serial !== 1'b1 || active !== 1'b0 || done !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL single_after: got serial %b active %b done %b count %0d want 1 0 0 0",
                         serial, active, done, count);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b; int bad, dc, dp, ina, w; bit to;
    dv = 1'b1; tx_byte = 8'hAB;
    @(negedge clk);
    tx_byte = 8'h3F;
    @(negedge clk);
    dv = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count: got %0d want 1", count); end
    wait_start(0, 5, w, to);
    checks++; if (to || w != 0) begin errors++; $display("FAIL b2b_latency: got %0d (timeout %b) want 0", w, to); end
    decode_frame(0, 87, 0, b, bad, dc, dp, ina);
    checks++; if (b !== 8'hAB || bad != 0 || dc != 1 || dp != 869 || ina != 0) begin
      errors++; $display("FAIL b2b_frame1: got byte %h bad %0d done %0d@%0d inactive %0d want ab 0 1@869 0",
                         b, bad, dc, dp, ina);
    end
    @(negedge clk);
    decode_frame(0, 87, 0, b, bad, dc, dp, ina);
    checks++; if (b !== 8'h3F || bad != 0 || dc != 1 || dp != 869 || ina != 0) begin
      errors++; $display("FAIL b2b_frame2: got byte %h bad %0d done %0d@%0d inactive %0d want 3f 0 1@869 0",
                         b, bad, dc, dp, ina);
    end
    @(negedge clk);
    checks++; if (serial !== 1'b1 || active !== 1'b0) begin
      errors++; $display("FAIL b2b_after: got serial %b active %b want 1 0", serial, active);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] b; int bad, dc, dp, ina, w; bit to;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        checks++; if (count !== 3'd4 || ready !== 1'b0 || ovf !== 1'b0) begin
          errors++; $display("FAIL ovf_full: got count %0d ready %b ovf %b want 4 0 0", count, ready, ovf);
        end
      end
      dv = 1'b1; tx_byte = 8'(i + 1);
      @(negedge clk);
    end
    dv = 1'b0;
    checks++; if (count !== 3'd4 || ready !== 1'b0 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_drop: got count %0d ready %b ovf %b want 4 0 1", count, ready, ovf);
    end
    decode_frame(0, 87, 4, b, bad, dc, dp, ina);
    checks++; if (b !== 8'h01 || bad != 0 || dc != 1) begin
      errors++; $display("FAIL ovf_byte1: got %h bad %0d done %0d want 01 0 1", b, bad, dc);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      decode_frame(0, 87, 0, b, bad, dc, dp, ina);
      checks++; if (b !== 8'(i + 2) || bad != 0 || dc != 1 || ina != 0) begin
        errors++; $display("FAIL ovf_byte%0d: got %h bad %0d done %0d want %h 0 1", i + 2, b, bad, dc, 8'(i + 2));
      end
    end
    @(negedge clk);
    checks++; if (serial !== 1'b1 || active !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL ovf_after: got serial %b active %b count %0d want 1 0 0", serial, active, count);
    end
    wait_start(0, 200, w, to);
    checks++; if (!to) begin errors++; $display("FAIL ovf_no_sixth: got frame start after %0d want none", w); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_push_pop;
    logic [7:0] b; logic [7:0] exp_b [4]; int bad, dc, dp, ina;
    exp_b[0] = 8'h12; exp_b[1] = 8'h13; exp_b[2] = 8'h14; exp_b[3] = 8'h21;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      dv = 1'b1; tx_byte = 8'h10 + 8'(i);
      @(negedge clk);
    end
    dv = 1'b0;
    checks++; if (count !== 3'd4 || ready !== 1'b0) begin
      errors++; $display("FAIL pp_full: got count %0d ready %b want 4 0", count, ready);
    end
    decode_frame(0, 87, 3, b, bad, dc, dp, ina);
    checks++; if (b !== 8'h10 || dp != 869 || ovf !== 1'b0) begin
      errors++; $display("FAIL pp_frame0: got byte %h done@%0d ovf %b want 10 869 0", b, dp, ovf);
    end
    dv = 1'b1; tx_byte = 8'h20;
    @(negedge clk);
    checks++; if (count !== 3'd3 || ovf !== 1'b1) begin
      errors++; $display("FAIL pp_edge_write: got count %0d ovf %b want 3 1", count, ovf);
    end
    tx_byte = 8'h21;
    @(negedge clk);
    dv = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL pp_next_write: got count %0d want 4", count); end
    decode_frame(0, 87, 1, b, bad, dc, dp, ina);
    checks++; if (b !== 8'h11 || bad != 0) begin
      errors++; $display("FAIL pp_frame1: got %h bad %0d want 11 0", b, bad);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      decode_frame(0, 87, 0, b, bad, dc, dp, ina);
      checks++; if (b !== exp_b[i] || bad != 0 || dc != 1) begin
        errors++; $display("FAIL pp_frame%0d: got %h bad %0d done %0d want %h 0 1", i + 2, b, bad, dc, exp_b[i]);
      end
    end
    @(negedge clk);
    checks++; if (active !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL pp_after: got active %b count %0d want 0 0", active, count);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b; int bad, dc, dp, ina, w; bit to;
    dv = 1'b1; tx_byte = 8'h3F;
    @(negedge clk);
    tx_byte = 8'h40;
    @(negedge clk);
    tx_byte = 8'h41;
    @(negedge clk);
    dv = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL rmf_queued: got %0d want 2", count); end
    repeat (618) @(negedge clk);
    checks++; if (serial !== 1'b0 || active !== 1'b1) begin
      errors++; $display("FAIL rmf_in_data: got serial %b active %b want 0 1", serial, active);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (serial !== 1'b1 || count !== 3'd0 || active !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rmf_async: got serial %b count %0d active %b done %b want 1 0 0 0",
                         serial, count, active, done);
    end
    checks++; if (ovf !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL rmf_flags: got ovf %b ready %b want 0 1", ovf, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_start(0, 2610, w, to);
    checks++; if (!to) begin errors++; $display("FAIL rmf_no_frames: got frame start after %0d want none", w); end
    dv = 1'b1; tx_byte = 8'h5A;
    @(negedge clk);
    dv = 1'b0;
    wait_start(0, 5, w, to);
    checks++; if (to || w != 1) begin errors++; $display("FAIL rmf_latency: got %0d (timeout %b) want 1", w, to); end
    decode_frame(0, 87, 0, b, bad, dc, dp, ina);
    checks++; if (b !== 8'h5A || bad != 0 || dc != 1) begin
      errors++; $display("FAIL rmf_first_byte: got %h bad %0d done %0d want 5a 0 1", b, bad, dc);
    end
    @(negedge clk);
  endtask

  task automatic test_param_sweep;
    logic [7:0] b; int bad, dc, dp, ina;
    s_dv = 1'b1; s_byte = 8'hA1;
    @(negedge clk);
    s_byte = 8'hB2;
    @(negedge clk);
    s_byte = 8'hC3;
    @(negedge clk);
    s_dv = 1'b0;
    checks++; if (s_count !== 2'd2 || s_ready !== 1'b0 || s_ovf !== 1'b0) begin
      errors++; $display("FAIL sweep_full: got count %0d ready %b ovf %b want 2 0 0", s_count, s_ready, s_ovf);
    end
    decode_frame(1, 4, 1, b, bad, dc, dp, ina);
    checks++; if (b !== 8'hA1 || bad != 0 || dc != 1 || dp != 39 || ina != 0) begin
      errors++; $display("FAIL sweep_frame1: got %h bad %0d done %0d@%0d inactive %0d want a1 0 1@39 0",
                         b, bad, dc, dp, ina);
    end
    @(negedge clk);
    checks++; if (s_count !== 2'd1 || s_ready !== 1'b1) begin
      errors++; $display("FAIL sweep_pop: got count %0d ready %b want 1 1", s_count, s_ready);
    end
    decode_frame(1, 4, 0, b, bad, dc, dp, ina);
    checks++; if (b !== 8'hB2 || bad != 0 || dp != 39) begin
      errors++; $display("FAIL sweep_frame2: got %h bad %0d done@%0d want b2 0 39", b, bad, dp);
    end
    @(negedge clk);
    decode_frame(1, 4, 0, b, bad, dc, dp, ina);
    checks++; if (b !== 8'hC3 || bad != 0 || dp != 39) begin
      errors++; $display("FAIL sweep_frame3: got %h bad %0d done@%0d want c3 0 39", b, bad, dp);
    end
    @(negedge clk);
    checks++; if (s_serial !== 1'b1 || s_active !== 1'b0 || s_count !== 2'd0) begin
      errors++; $display("FAIL sweep_after: got serial %b active %b count %0d want 1 0 0",
                         s_serial, s_active, s_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop();
    test_reset_mid_frame();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1000000 want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
